deadtime_gate_driver: RTL
=========================

DEADTIME_GATE_DRIVER -- requirements
Module: deadtime_gate_driver

Interface
REQ-001 SHALL have parameter DT_WIDTH, default 8: width of the dead-time input and counter.
REQ-002 SHALL have parameter DWELL_WIDTH, default 16: width of the min-dwell input, dwell counter and switch counter.
REQ-003 SHALL have port i_clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_RESET  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port i_sigma  input  1  requested switching variable from the hybrid controller (1 = positive bridge state).
REQ-006 SHALL have port i_enable  input  1  bridge enable; 0 forces all gates off.
REQ-007 SHALL have port i_deadtime  input  DT_WIDTH  dead-time in clock cycles, unsigned.
REQ-008 SHALL have port i_min_dwell  input  DWELL_WIDTH  minimum ON-state duration in cycles, unsigned.
REQ-009 SHALL have port o_gate  output  4  gate commands {Q1,Q2,Q3,Q4}, registered.
REQ-010 SHALL have port o_sigma_applied  output  1  polarity currently applied to the bridge, registered.
REQ-011 SHALL have port o_busy  output  1  high while in a dead-time state, registered.
REQ-012 SHALL have port o_switch_count  output  DWELL_WIDTH  count of completed commutations, registered.

Function
REQ-013 SHALL implement states IDLE, DT_TO_P, ON_P, DT_TO_N, ON_N.
REQ-014 SHALL drive o_gate: 4'b1001 in ON_P, 4'b0110 in ON_N, 4'b0000 in IDLE and both DT states.
REQ-015 SHALL never assert Q1&Q2 or Q3&Q4 in any cycle, including state transitions.
REQ-016 IDLE: when i_enable=1, SHALL go to DT_TO_P if i_sigma=1, else DT_TO_N, next edge.
REQ-017 DT states: SHALL hold max(i_deadtime,1) cycles with gates off, then enter the target ON state.
REQ-018 SHALL load the dead-time counter on DT entry; i_deadtime changes during a DT state SHALL not affect it.
REQ-019 SHALL not abort a DT state when i_sigma reverts; the target ON state is entered and normal dwell rules apply.
REQ-020 ON states: SHALL count cycles in a saturating dwell counter, cleared on entry.
REQ-021 SHALL leave ON_P for DT_TO_N only when i_sigma=0 and dwell count >= i_min_dwell; ON_N to DT_TO_P symmetric with i_sigma=1.
REQ-022 SHALL ignore sigma changes during dwell; they are honoured once the dwell is satisfied, if still present.
REQ-023 Latency: sigma toggle sampled at edge k with dwell satisfied SHALL give o_gate=0000 after edge k.
REQ-024 i_enable=0 sampled in any state SHALL give IDLE and o_gate=0000 after that edge; this SHALL take priority over all other transitions.
REQ-025 o_sigma_applied SHALL be 1 in ON_P, 0 in ON_N, and hold its previous value in DT and IDLE.
REQ-026 o_switch_count SHALL increment by 1 on each DT-to-ON transition and wrap from all-ones to 0.
REQ-027 o_busy SHALL equal 1 exactly in DT_TO_P and DT_TO_N.

Reset
REQ-028 i_RESET=0 at an edge SHALL give state IDLE, o_gate=0000, o_sigma_applied=0, o_busy=0, o_switch_count=0 and all counters 0.
REQ-029 Reset mid-DT or mid-ON SHALL take effect at that edge, overriding enable and sigma.
REQ-030 After release, the block SHALL follow REQ-016; no ON state SHALL be reachable without passing a DT state.

Structure
REQ-031 State encoding and gate patterns (GATE_P=1001, GATE_N=0110, GATE_OFF=0000) SHALL be in a shared definitions package/include used by controller-side blocks.
REQ-032 Dead-time and dwell timing SHALL use one sub-module, hc_timer: loadable down/up counter with saturation and a done flag, instantiated twice.

Verification
REQ-033 Bench SHALL cover: reset release, enable=1, sigma=1, deadtime=5 -> gates 0000 for 5 cycles, then 1001, switch_count=1.
REQ-034 Bench SHALL cover: in ON_P with min_dwell=20, sigma->0 at dwell cycle 3 -> gates stay 1001 until dwell 20, then 0000 next edge.
REQ-035 Bench SHALL cover: deadtime=0 -> exactly 1 cycle of 0000 between 1001 and 0110.
REQ-036 Bench SHALL cover: sigma pulses 1->0->1 inside a DT_TO_N of 8 cycles -> ON_N entered, gates 0110, then after dwell DT_TO_P.
REQ-037 Bench SHALL cover: enable=0 mid-ON and reset=0 mid-DT -> 0000 the next edge; 65536 commutations -> switch_count wraps to 0.
REQ-038 Bench SHALL cover: a continuous assertion check, over random sigma/enable/deadtime, that Q1&Q2 and Q3&Q4 are never high.

Source files
------------

// File: rtl/deadtime_gate_driver_pkg.sv
// Shared state encoding and gate patterns for the H-bridge gate driver
// and any controller-side block that needs to interpret them.
package deadtime_gate_driver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DT_TO_P,
    ON_P,
    DT_TO_N,
    ON_N
  } state_t;

  // {Q1,Q2,Q3,Q4}
  localparam logic [3:0] GATE_P   = 4'b1001;
  localparam logic [3:0] GATE_N   = 4'b0110;
  localparam logic [3:0] GATE_OFF = 4'b0000;

  function automatic logic [3:0] gate_for(input state_t s);
    case (s)
      ON_P:    return GATE_P;
      ON_N:    return GATE_N;
      default: return GATE_OFF;
    endcase
  endfunction

  function automatic logic is_dead(input state_t s);
    return (s == DT_TO_P) || (s == DT_TO_N);
  endfunction

endpackage

// File: rtl/hc_timer.sv
// Loadable saturating counter (down or up) with a done flag comparing the
// count against a target: count <= target when counting down, >= when up.
module hc_timer #(
  parameter int WIDTH      = 8,
  parameter bit COUNT_DOWN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             run,
  input  logic [WIDTH-1:0] target,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (run) begin
      if (COUNT_DOWN) begin
        if (count != '0) count <= count - WIDTH'(1);
      end else begin
        if (count != '1) count <= count + WIDTH'(1);
      end
    end
  end

  assign done = COUNT_DOWN ? (count <= target) : (count >= target);

endmodule

// File: rtl/deadtime_gate_driver.sv
// Full-bridge gate sequencer: inserts a dead-time between polarity changes
// and enforces a minimum ON dwell before honouring a new switching request.
module deadtime_gate_driver
  import deadtime_gate_driver_pkg::*;
#(
  parameter int DT_WIDTH    = 8,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   i_clock,
  input  logic                   i_RESET,
  input  logic                   i_sigma,
  input  logic                   i_enable,
  input  logic [DT_WIDTH-1:0]    i_deadtime,
  input  logic [DWELL_WIDTH-1:0] i_min_dwell,
  output logic [3:0]             o_gate,
  output logic                   o_sigma_applied,
  output logic                   o_busy,
  output logic [DWELL_WIDTH-1:0] o_switch_count
);

  state_t state, state_next;

  logic dt_load, dt_run, dt_done;
  logic dwell_load, dwell_run, dwell_done;
  logic commutate;
  logic [DT_WIDTH-1:0] dt_load_value;

  // Loading N-1 and finishing on zero gives exactly max(N,1) dead cycles.
  assign dt_load_value = (i_deadtime == '0) ? '0 : i_deadtime - DT_WIDTH'(1);

  always_comb begin
    state_next = state;
    dt_load    = 1'b0;
    dt_run     = 1'b0;
    dwell_load = 1'b0;
    dwell_run  = 1'b0;
    commutate  = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable) begin
          state_next = i_sigma ? DT_TO_P : DT_TO_N;
          dt_load    = 1'b1;
        end
      end
      DT_TO_P, DT_TO_N: begin
        dt_run = 1'b1;
        if (dt_done) begin
          state_next = (state == DT_TO_P) ? ON_P : ON_N;
          dwell_load = 1'b1;
          commutate  = 1'b1;
        end
      end
      ON_P: begin
        dwell_run = 1'b1;
        if (!i_sigma && dwell_done) begin
          state_next = DT_TO_N;
          dt_load    = 1'b1;
        end
      end
      ON_N: begin
        dwell_run = 1'b1;
        if (i_sigma && dwell_done) begin
          state_next = DT_TO_P;
          dt_load    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!i_enable) begin
      state_next = IDLE;
      dt_load    = 1'b0;
      dwell_load = 1'b0;
      commutate  = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clock) begin
    if (!i_RESET) begin
      state           <= IDLE;
      o_gate          <= GATE_OFF;
      o_sigma_applied <= 1'b0;
      o_busy          <= 1'b0;
      o_switch_count  <= '0;
    end else begin
      state  <= state_next;
      o_gate <= gate_for(state_next);
      o_busy <= is_dead(state_next);
      if (state_next == ON_P) o_sigma_applied <= 1'b1;
      else if (state_next == ON_N) o_sigma_applied <= 1'b0;
      if (commutate) o_switch_count <= o_switch_count + DWELL_WIDTH'(1);
    end
  end

  hc_timer #(
    .WIDTH      (DT_WIDTH),
    .COUNT_DOWN (1'b1)
  ) dt_timer (
    .clk        (i_clock),
    .rst_n      (i_RESET),
    .load       (dt_load),
    .load_value (dt_load_value),
    .run        (dt_run),
    .target     ('0),
    .done       (dt_done)
  );

  hc_timer #(
    .WIDTH      (DWELL_WIDTH),
    .COUNT_DOWN (1'b0)
  ) dwell_timer (
    .clk        (i_clock),
    .rst_n      (i_RESET),
    .load       (dwell_load),
    .load_value ('0),
    .run        (dwell_run),
    .target     (i_min_dwell),
    .done       (dwell_done)
  );

endmodule
